// File: rtl/mul_pkg.sv
// Shared encodings for the sequential Booth multiplier.
// Pure declarations: no logic, no latency.
// Not applicable: no handshake lives here.
package mul_pkg;

  // FSM state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    STEP = S_STEP,
    DONE = S_DONE
  } state_t;

  // Booth codes, read as {Q[0], q_1}
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Result word layout, LSB first: product, then the mode bit, then the ID tag
  localparam int PROD_LSB = 0;

  function automatic int mode_pos(input int n);
    return 2 * n;
  endfunction

  function automatic int id_lsb(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/add_sub.sv
// Generic adder/subtractor: sum = a + (sub ? ~b : b) + cin.
// Combinational, zero latency.
// No handshake.
module add_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] b_op;

  // Invert the second operand for subtraction; the caller supplies cin=1 to complete two's complement
  always_comb begin
    b_op = sub ? ~b : b;
    sum  = a + b_op + {{(W-1){1'b0}}, cin};
  end

endmodule

// File: rtl/mul_booth_fsm_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of A into P, then arithmetic shift of {P, Q, q_1}.
// Combinational, zero latency.
// No handshake; the FSM decides when the result is registered.
module booth_step
  import mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N+1:0] p,
  input  logic [N:0]   q,
  input  logic         q_1,
  input  logic [N:0]   a,
  output logic [N+1:0] p_nxt,
  output logic [N:0]   q_nxt,
  output logic         q1_nxt
);

  logic [1:0]   code;
  logic         sub;
  logic [N+1:0] a_ext;
  logic [N+1:0] sum;
  logic [N+1:0] p_sel;

  // Decode the Booth pair and widen A by one guard bit so P can never overflow
  always_comb begin
    code  = {q[0], q_1};
    sub   = (code == BOOTH_SUB);
    a_ext = {a[N], a};
  end

  add_sub #(.W(N + 2)) u_add_sub (
    .a   (p),
    .b   (a_ext),
    .sub (sub),
    .cin (sub),
    .sum (sum)
  );

  // Keep P for codes 00/11, then shift the whole {P, Q, q_1} chain right arithmetically
  always_comb begin
    p_sel  = ((code == BOOTH_ADD) || (code == BOOTH_SUB)) ? sum : p;
    p_nxt  = {p_sel[N+1], p_sel[N+1:1]};
    q_nxt  = {p_sel[0], q[N:1]};
    q1_nxt = q[0];
  end

endmodule

// File: rtl/mul_booth_fsm.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation, ID tag carried to the result.
// Accept to result valid: N+1 STEP cycles; result then held until taken; issue interval N+3 cycles.
// Accepts only in IDLE with result FIFO not full; result held stable in DONE until ready_f_res.
module mul_booth_fsm
  import mul_pkg::*;
#(
  parameter int OP_WIDTH = 8,
  parameter int ID_SIZE  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [OP_WIDTH-1:0]           a_in,
  input  logic [OP_WIDTH-1:0]           b_in,
  input  logic                          signed_mode,
  input  logic [ID_SIZE-1:0]            id_mul,
  input  logic                          m_valid_data,
  output logic                          m_ready_data,
  input  logic                          ready_f_res,
  output logic                          m_valid_res,
  output logic [ID_SIZE+2*OP_WIDTH:0]   result_mul,
  output logic                          busy
);

  localparam int N         = OP_WIDTH;
  localparam int CNT_WIDTH = $clog2(OP_WIDTH + 1) + 1;
  localparam int RES_W     = ID_SIZE + 1 + 2 * OP_WIDTH;
  localparam int MODE_POS  = mode_pos(OP_WIDTH);
  localparam int ID_LSB    = id_lsb(OP_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(OP_WIDTH);

  state_t state_q, state_d;

  logic [N:0]           a_q;
  logic [N:0]           q_q;
  logic [N+1:0]         p_q;
  logic                 q1_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [ID_SIZE-1:0]   id_q;
  logic                 mode_q;
  logic [RES_W-1:0]     res_q;

  logic [N+1:0]         p_nxt;
  logic [N:0]           q_nxt;
  logic                 q1_nxt;
  logic                 accept;
  logic                 last_iter;
  logic [2*N-1:0]       prod_nxt;

  booth_step #(.N(N)) u_booth_step (
    .p      (p_q),
    .q      (q_q),
    .q_1    (q1_q),
    .a      (a_q),
    .p_nxt  (p_nxt),
    .q_nxt  (q_nxt),
    .q1_nxt (q1_nxt)
  );

  // Handshake qualifiers and the product seen after the final iteration
  always_comb begin
    accept    = (state_q == IDLE) && m_valid_data && ready_f_res && !rst;
    last_iter = (cnt_q == LAST_ITER);
    prod_nxt  = {p_nxt[N-2:0], q_nxt};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d      = state_q;
    m_ready_data = 1'b0;
    m_valid_res  = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        m_ready_data = ready_f_res && !rst;
        if (accept) state_d = STEP;
      end
      STEP: begin
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        m_valid_res = 1'b1;
        if (ready_f_res) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load extended operands on accept, iterate in STEP, capture the result word on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      q_q    <= '0;
      p_q    <= '0;
      q1_q   <= 1'b0;
      cnt_q  <= '0;
      id_q   <= '0;
      mode_q <= 1'b0;
      res_q  <= '0;
    end else if (accept) begin
      a_q    <= signed_mode ? {a_in[N-1], a_in} : {1'b0, a_in};
      q_q    <= signed_mode ? {b_in[N-1], b_in} : {1'b0, b_in};
      p_q    <= '0;
      q1_q   <= 1'b0;
      cnt_q  <= '0;
      id_q   <= id_mul;
      mode_q <= signed_mode;
    end else if (state_q == STEP) begin
      p_q   <= p_nxt;
      q_q   <= q_nxt;
      q1_q  <= q1_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) begin
        res_q[ID_LSB +: ID_SIZE]  <= id_q;
        res_q[MODE_POS]           <= mode_q;
        res_q[PROD_LSB +: 2 * N]  <= prod_nxt;
      end
    end
  end

  assign result_mul = res_q;

endmodule
